// File: rtl/conv_pkg.sv
// Shared types and constants for the conv2d_engine block: FSM states,
// memory opcodes and the job header layout.
package conv_pkg;

  typedef enum logic [3:0] {
    IDLE,
    HDR_RD,
    CHECK,
    ROW,
    COL,
    FETCH_A,
    FETCH_F,
    MAC,
    WRITE,
    DONE
  } state_t;

  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b11;

  localparam int HDR_WORDS = 5;

  // Word offsets of the header fields relative to the job base address.
  localparam logic [2:0] HDR_WA = 3'd0;
  localparam logic [2:0] HDR_HA = 3'd1;
  localparam logic [2:0] HDR_WF = 3'd2;
  localparam logic [2:0] HDR_HF = 3'd3;
  localparam logic [2:0] HDR_S  = 3'd4;

endpackage

// File: rtl/conv_addr_gen.sv
// Combinational address generator: header, A-tap, F-tap and result addresses
// derived from the latched job geometry. All arithmetic wraps at ADDR_W bits.
module conv_addr_gen
  import conv_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] i_base,
  input  logic [ADDR_W-1:0] i_wa,
  input  logic [ADDR_W-1:0] i_ha,
  input  logic [ADDR_W-1:0] i_wf,
  input  logic [ADDR_W-1:0] i_hf,
  input  logic [ADDR_W-1:0] i_row,      // i*S
  input  logic [ADDR_W-1:0] i_col,      // j*S
  input  logic [ADDR_W-1:0] i_k,
  input  logic [ADDR_W-1:0] i_l,
  input  logic [ADDR_W-1:0] i_out_idx,  // i*OW + j
  input  logic [2:0]        i_hdr_idx,
  output logic [ADDR_W-1:0] o_hdr_addr,
  output logic [ADDR_W-1:0] o_a_addr,
  output logic [ADDR_W-1:0] o_f_addr,
  output logic [ADDR_W-1:0] o_r_addr
);

  logic [ADDR_W-1:0] w_a_base;
  logic [ADDR_W-1:0] w_f_base;
  logic [ADDR_W-1:0] w_r_base;

  assign w_a_base = i_base + ADDR_W'(HDR_WORDS);
  assign w_f_base = w_a_base + i_ha * i_wa;
  assign w_r_base = w_f_base + i_hf * i_wf;

  assign o_hdr_addr = i_base + ADDR_W'(i_hdr_idx);
  assign o_a_addr   = w_a_base + (i_row + i_k) * i_wa + i_col + i_l;
  assign o_f_addr   = w_f_base + i_k * i_wf + i_l;
  assign o_r_addr   = w_r_base + i_out_idx;

endmodule

// File: rtl/conv2d_engine.sv
// 2D convolution engine over shared word RAM with signed saturating MAC.
// Optional CONV_RELU_EN clamps negative results to zero before the write.
module conv2d_engine
  import conv_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int ACC_W  = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              mem_opdone,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [1:0]        mem_operation,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int XW = ADDR_W + 2;
  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = (ACC_W'(1) << (DATA_W - 1)) - ACC_W'(1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  state_t r_state, w_state_nxt;

  logic [ADDR_W-1:0] r_base, r_wa, r_ha, r_wf, r_hf, r_s;
  logic [ADDR_W-1:0] r_row, r_col, r_k, r_l, r_out_idx;
  logic [2:0]        r_hdr_idx;
  logic [DATA_W-1:0] r_op1, r_op2;
  logic signed [ACC_W-1:0] r_acc;
  logic [1:0]        r_mem_op;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic              r_busy, r_done, r_err;

  logic [ADDR_W-1:0] w_hdr_addr, w_a_addr, w_f_addr, w_r_addr, w_req_addr;
  logic [1:0]        w_req_op;
  logic [DATA_W-1:0] w_sat;
  logic signed [ACC_W-1:0] w_prod;
  logic w_ack, w_dim_bad, w_last_tap, w_last_col, w_last_row;

  conv_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .i_base     (r_base),
    .i_wa       (r_wa),
    .i_ha       (r_ha),
    .i_wf       (r_wf),
    .i_hf       (r_hf),
    .i_row      (r_row),
    .i_col      (r_col),
    .i_k        (r_k),
    .i_l        (r_l),
    .i_out_idx  (r_out_idx),
    .i_hdr_idx  (r_hdr_idx),
    .o_hdr_addr (w_hdr_addr),
    .o_a_addr   (w_a_addr),
    .o_f_addr   (w_f_addr),
    .o_r_addr   (w_r_addr)
  );

  // mem_opdone only counts while a transaction is actually outstanding.
  assign w_ack      = (r_mem_op != MEM_NONE) && mem_opdone;
  assign w_dim_bad  = (r_wa == '0) || (r_ha == '0) || (r_wf == '0) || (r_hf == '0) ||
                      (r_s == '0) || (r_hf > r_ha) || (r_wf > r_wa);
  assign w_last_tap = (r_l == r_wf - ONE) && (r_k == r_hf - ONE);
  assign w_last_col = (XW'(r_col) + XW'(r_s) + XW'(r_wf)) > XW'(r_wa);
  assign w_last_row = (XW'(r_row) + XW'(r_s) + XW'(r_hf)) > XW'(r_ha);
  assign w_prod     = ACC_W'(signed'(r_op1)) * ACC_W'(signed'(r_op2));

  always_comb begin
    if (r_acc > SAT_MAX)      w_sat = SAT_MAX[DATA_W-1:0];
    else if (r_acc < SAT_MIN) w_sat = SAT_MIN[DATA_W-1:0];
    else                      w_sat = r_acc[DATA_W-1:0];
`ifdef CONV_RELU_EN
    if (r_acc[ACC_W-1]) w_sat = '0;
`endif
  end

  // NOTE: every signal assigned in this block gets a default first, so no
  // path through the case can leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_req_op    = MEM_NONE;
    w_req_addr  = w_hdr_addr;
    case (r_state)
      IDLE, DONE: if (start) w_state_nxt = HDR_RD;
      HDR_RD: begin
        w_req_op = MEM_READ;
        if (w_ack && r_hdr_idx == HDR_S) w_state_nxt = CHECK;
      end
      CHECK:   w_state_nxt = w_dim_bad ? DONE : ROW;
      ROW:     w_state_nxt = COL;
      COL:     w_state_nxt = FETCH_A;
      FETCH_A: begin
        w_req_op   = MEM_READ;
        w_req_addr = w_a_addr;
        if (w_ack) w_state_nxt = FETCH_F;
      end
      FETCH_F: begin
        w_req_op   = MEM_READ;
        w_req_addr = w_f_addr;
        if (w_ack) w_state_nxt = MAC;
      end
      MAC:     w_state_nxt = w_last_tap ? WRITE : FETCH_A;
      WRITE: begin
        w_req_op   = MEM_WRITE;
        w_req_addr = w_r_addr;
        if (w_ack) w_state_nxt = (w_last_col && w_last_row) ? DONE : ROW;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // Bus request is registered: it appears the cycle after state entry and is
  // dropped the cycle after the ack, which forces an idle gap between requests.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mem_op <= MEM_NONE;
      r_addr   <= '0;
      r_data   <= '0;
    end else if (r_mem_op != MEM_NONE) begin
      if (mem_opdone) r_mem_op <= MEM_NONE;
    end else if (w_req_op != MEM_NONE) begin
      r_mem_op <= w_req_op;
      r_addr   <= w_req_addr;
      if (w_req_op == MEM_WRITE) r_data <= w_sat;
    end
  end

  // NOTE: the design holds only flops, no RAM arrays, so every register is
  // cleared by the asynchronous reset and a mid-job reset aborts cleanly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_base <= '0; r_wa <= '0; r_ha <= '0; r_wf <= '0; r_hf <= '0; r_s <= '0;
      r_row  <= '0; r_col <= '0; r_k <= '0; r_l <= '0; r_out_idx <= '0;
      r_hdr_idx <= '0;
      r_op1  <= '0; r_op2 <= '0; r_acc <= '0;
      r_busy <= 1'b0; r_done <= 1'b0; r_err <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: if (start) begin
          r_base    <= base_addr;
          r_hdr_idx <= '0;
          r_busy    <= 1'b1;
          r_done    <= 1'b0;
          r_err     <= 1'b0;
        end
        HDR_RD: if (w_ack) begin
          case (r_hdr_idx)
            HDR_WA:  r_wa <= ADDR_W'(data_i);
            HDR_HA:  r_ha <= ADDR_W'(data_i);
            HDR_WF:  r_wf <= ADDR_W'(data_i);
            HDR_HF:  r_hf <= ADDR_W'(data_i);
            HDR_S:   r_s  <= ADDR_W'(data_i);
            default: ;
          endcase
          r_hdr_idx <= r_hdr_idx + 3'd1;
        end
        CHECK: begin
          r_row <= '0; r_col <= '0; r_k <= '0; r_l <= '0;
          r_out_idx <= '0;
          r_acc     <= '0;
          if (w_dim_bad) begin
            r_err  <= 1'b1;
            r_done <= 1'b1;
            r_busy <= 1'b0;
          end
        end
        FETCH_A: if (w_ack) r_op1 <= data_i;
        FETCH_F: if (w_ack) r_op2 <= data_i;
        MAC: begin
          r_acc <= r_acc + w_prod;
          if (r_l == r_wf - ONE) begin
            r_l <= '0;
            r_k <= (r_k == r_hf - ONE) ? '0 : r_k + ONE;
          end else begin
            r_l <= r_l + ONE;
          end
        end
        WRITE: if (w_ack) begin
          r_acc     <= '0;
          r_out_idx <= r_out_idx + ONE;
          if (w_last_col) begin
            r_col <= '0;
            r_row <= r_row + r_s;
          end else begin
            r_col <= r_col + r_s;
          end
          if (w_last_col && w_last_row) begin
            r_done <= 1'b1;
            r_busy <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign data_o        = r_data;
  assign addr_o        = r_addr;
  assign mem_operation = r_mem_op;
  assign busy          = r_busy;
  assign done          = r_done;
  assign err           = r_err;

endmodule
